// File: rtl/pac_pkg.sv
// Shared definitions for the packet action dispatcher: word/tag layout,
// action field positions, forwarding mode codes, port indices, read FSM states
// and the destination-mask decode.
package pac_pkg;

  localparam int unsigned PAC_DW    = 134;
  localparam int unsigned ACT_W     = 11;
  localparam int unsigned NUM_PORTS = 3;

  // Word tag in bits [133:132]
  localparam int unsigned TAG_HI = 133;
  localparam int unsigned TAG_LO = 132;
  localparam logic [1:0]  TAG_FIRST = 2'b01;
  localparam logic [1:0]  TAG_MID   = 2'b11;
  localparam logic [1:0]  TAG_LAST  = 2'b10;

  // Action fields
  localparam int unsigned ACT_MODE_HI = 10;
  localparam int unsigned ACT_MODE_LO = 9;
  localparam int unsigned ACT_TYPE_HI = 8;
  localparam int unsigned ACT_TYPE_LO = 6;
  localparam int unsigned ACT_PORT_HI = 5;
  localparam int unsigned ACT_PORT_LO = 0;

  localparam logic [1:0] MODE_UNICAST = 2'b00;
  localparam logic [1:0] MODE_BCAST   = 2'b10;

  localparam int unsigned PORT_RING0  = 0;
  localparam int unsigned PORT_RING1  = 1;
  localparam int unsigned PORT_DIRECT = 2;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ARB  = 2'd1,
    RD_SEND = 2'd2,
    RD_DISC = 2'd3
  } rd_state_e;

  // Unicast selects one of ports 0..2; broadcast selects ring port{port[0]}
  // plus the direct port. Anything else yields an empty mask (discard).
  function automatic logic [NUM_PORTS-1:0] dest_mask(input logic [1:0] mode,
                                                     input logic [5:0] port);
    logic [NUM_PORTS-1:0] m;
    m = '0;
    if (mode == MODE_UNICAST) begin
      if (port == 6'(PORT_RING0))       m[PORT_RING0]  = 1'b1;
      else if (port == 6'(PORT_RING1))  m[PORT_RING1]  = 1'b1;
      else if (port == 6'(PORT_DIRECT)) m[PORT_DIRECT] = 1'b1;
    end else if (mode == MODE_BCAST && port[5:1] == '0) begin
      if (port[0]) m[PORT_RING1] = 1'b1;
      else         m[PORT_RING0] = 1'b1;
      m[PORT_DIRECT] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/pac_sfifo.sv
// Synchronous show-ahead FIFO with empty/full flags and used-word count.
// Status comes from registered pointers, so a write into an empty FIFO
// becomes visible to the reader one cycle later (no bypass).
module pac_sfifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   used_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             do_wr;
  logic             do_rd;

  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;
  assign used_o    = wptr_q - rptr_q;
  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rptr_q[AW-1:0]];

  // Storage array, written at the write pointer
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

  // Pointer advance on accepted writes/reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/pac_dispatch.sv
// Packet action consumer: buffers packet words and per-packet {valid, action},
// then replicates each packet to ring ports 0/1 and/or direct port 2.
// Optional macro PAC_PORT_CNT_EN adds per-port wrap-around packet counters.
module pac_dispatch
  import pac_pkg::*;
#(
  parameter int unsigned DATA_DEPTH    = 512,
  parameter int unsigned ACT_DEPTH     = 16,
  parameter int unsigned MAX_PKT_WORDS = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PAC_DW-1:0] in_pac_data,
  input  logic              in_pac_data_wr,
  input  logic              in_pac_valid,
  input  logic              in_pac_valid_wr,
  input  logic [ACT_W-1:0]  in_pac_action,
  input  logic              in_pac_action_wr,
  output logic [PAC_DW-1:0] out_p0_data,
  output logic              out_p0_data_wr,
  output logic              out_p0_valid_wr,
  output logic              out_p0_valid,
  output logic [PAC_DW-1:0] out_p1_data,
  output logic              out_p1_data_wr,
  output logic              out_p1_valid_wr,
  output logic              out_p1_valid,
  output logic [PAC_DW-1:0] out_p2_data,
  output logic              out_p2_data_wr,
  output logic              out_p2_valid_wr,
  output logic              out_p2_valid,
  input  logic              in_p0_alf,
  input  logic              in_p1_alf,
  input  logic              in_p2_alf,
  output logic [31:0]       out_drop_cnt
`ifdef PAC_PORT_CNT_EN
  ,
  output logic [31:0]       out_p0_pkt_cnt,
  output logic [31:0]       out_p1_pkt_cnt,
  output logic [31:0]       out_p2_pkt_cnt
`endif
);

  localparam int unsigned DAW = $clog2(DATA_DEPTH);
  localparam int unsigned AAW = $clog2(ACT_DEPTH);

  // FIFO interconnect
  logic [PAC_DW-1:0] data_rdata;
  logic              data_wr, data_rd, data_empty, data_full;
  logic [DAW:0]      data_used;
  logic [ACT_W:0]    act_wdata, act_rdata;
  logic              act_wr, act_rd, act_empty, act_full;
  logic [AAW:0]      act_used;

  // Write side
  logic              drop_pkt_q;
  logic [ACT_W-1:0]  act_hold_q;
  logic              is_first, is_last, admit, drop_word, wr_drop_inc;
  logic [31:0]       data_free;

  // Read side
  rd_state_e                  state_q;
  logic [NUM_PORTS-1:0]       mask_q;
  logic                       pval_q;
  logic [NUM_PORTS-1:0]       alf;
  logic                       rd_last, rd_drop_inc;
  logic [NUM_PORTS-1:0]       out_wr_q, out_vwr_q, out_val_q;
  logic [NUM_PORTS-1:0][PAC_DW-1:0] out_data_q;
  logic [2:0]                 act_type_unused;

  logic [31:0] drop_cnt_q, drop_cnt_d;
  logic [32:0] drop_sum;

  pac_sfifo #(.WIDTH(PAC_DW), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (data_wr),
    .wr_data_i (in_pac_data),
    .rd_en_i   (data_rd),
    .rd_data_o (data_rdata),
    .empty_o   (data_empty),
    .full_o    (data_full),
    .used_o    (data_used)
  );

  pac_sfifo #(.WIDTH(ACT_W + 1), .DEPTH(ACT_DEPTH)) u_act_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (act_wr),
    .wr_data_i (act_wdata),
    .rd_en_i   (act_rd),
    .rd_data_o (act_rdata),
    .empty_o   (act_empty),
    .full_o    (act_full),
    .used_o    (act_used)
  );

  // Admission is decided on the first word; later words follow drop_pkt_q.
  // The action may arrive together with the last word, so the commit takes
  // the live action in that case and the held one otherwise.
  always_comb begin
    is_first    = in_pac_data_wr && (in_pac_data[TAG_HI:TAG_LO] == TAG_FIRST);
    is_last     = in_pac_data_wr && (in_pac_data[TAG_HI:TAG_LO] == TAG_LAST);
    data_free   = 32'(DATA_DEPTH) - 32'(data_used);
    admit       = (data_free >= MAX_PKT_WORDS) && (32'(act_used) < ACT_DEPTH);
    drop_word   = is_first ? !admit : drop_pkt_q;
    data_wr     = in_pac_data_wr && !drop_word && !data_full;
    act_wr      = in_pac_valid_wr && !drop_pkt_q && !act_full;
    act_wdata   = {in_pac_valid, (in_pac_action_wr ? in_pac_action : act_hold_q)};
    wr_drop_inc = is_last && drop_pkt_q;
  end

  // Write-side packet drop flag and action holding register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_pkt_q <= 1'b0;
      act_hold_q <= '0;
    end else begin
      if (is_first)     drop_pkt_q <= !admit;
      else if (is_last) drop_pkt_q <= 1'b0;
      if (in_pac_action_wr && !drop_pkt_q) act_hold_q <= in_pac_action;
    end
  end

  assign alf             = {in_p2_alf, in_p1_alf, in_p0_alf};
  assign rd_last         = (data_rdata[TAG_HI:TAG_LO] == TAG_LAST);
  assign act_type_unused = act_rdata[ACT_TYPE_HI:ACT_TYPE_LO];

  // FIFO pops requested by the read FSM
  always_comb begin
    act_rd      = 1'b0;
    data_rd     = 1'b0;
    rd_drop_inc = 1'b0;
    case (state_q)
      RD_IDLE: act_rd = !act_empty;
      RD_SEND: data_rd = !data_empty;
      RD_DISC: begin
        data_rd     = !data_empty;
        rd_drop_inc = !data_empty && rd_last;
      end
      default: ;
    endcase
  end

  // Read FSM with registered per-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RD_IDLE;
      mask_q     <= '0;
      pval_q     <= 1'b0;
      out_wr_q   <= '0;
      out_vwr_q  <= '0;
      out_val_q  <= '0;
      out_data_q <= '0;
    end else begin
      out_wr_q   <= '0;
      out_vwr_q  <= '0;
      out_val_q  <= '0;
      out_data_q <= '0;
      case (state_q)
        RD_IDLE: begin
          if (!act_empty) begin
            mask_q  <= dest_mask(act_rdata[ACT_MODE_HI:ACT_MODE_LO],
                                 act_rdata[ACT_PORT_HI:ACT_PORT_LO]);
            pval_q  <= act_rdata[ACT_W];
            state_q <= RD_ARB;
          end
        end
        RD_ARB: begin
          if (mask_q == '0)              state_q <= RD_DISC;
          else if ((mask_q & alf) == '0) state_q <= RD_SEND;
        end
        RD_SEND: begin
          if (!data_empty) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
              if (mask_q[p]) begin
                out_data_q[p] <= data_rdata;
                out_wr_q[p]   <= 1'b1;
                out_vwr_q[p]  <= rd_last;
                out_val_q[p]  <= rd_last && pval_q;
              end
            end
            if (rd_last) state_q <= RD_IDLE;
          end
        end
        RD_DISC: begin
          if (!data_empty && rd_last) state_q <= RD_IDLE;
        end
        default: state_q <= RD_IDLE;
      endcase
    end
  end

  // Write- and read-side drops in one cycle both count
  always_comb begin
    drop_sum   = {1'b0, drop_cnt_q} + {32'b0, wr_drop_inc} + {32'b0, rd_drop_inc};
    drop_cnt_d = drop_sum[32] ? '1 : drop_sum[31:0];
  end

  // Saturating drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign out_drop_cnt    = drop_cnt_q;
  assign out_p0_data     = out_data_q[PORT_RING0];
  assign out_p0_data_wr  = out_wr_q[PORT_RING0];
  assign out_p0_valid_wr = out_vwr_q[PORT_RING0];
  assign out_p0_valid    = out_val_q[PORT_RING0];
  assign out_p1_data     = out_data_q[PORT_RING1];
  assign out_p1_data_wr  = out_wr_q[PORT_RING1];
  assign out_p1_valid_wr = out_vwr_q[PORT_RING1];
  assign out_p1_valid    = out_val_q[PORT_RING1];
  assign out_p2_data     = out_data_q[PORT_DIRECT];
  assign out_p2_data_wr  = out_wr_q[PORT_DIRECT];
  assign out_p2_valid_wr = out_vwr_q[PORT_DIRECT];
  assign out_p2_valid    = out_val_q[PORT_DIRECT];

`ifdef PAC_PORT_CNT_EN
  logic [NUM_PORTS-1:0][31:0] pkt_cnt_q;

  // Per-port wrap-around packet counters, one count per valid_wr
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        pkt_cnt_q[p] <= pkt_cnt_q[p] + 32'(out_vwr_q[p]);
      end
    end
  end

  assign out_p0_pkt_cnt = pkt_cnt_q[PORT_RING0];
  assign out_p1_pkt_cnt = pkt_cnt_q[PORT_RING1];
  assign out_p2_pkt_cnt = pkt_cnt_q[PORT_DIRECT];
`endif

endmodule

// File: tb/tb_pac_dispatch.sv
// Directed bench for pac_dispatch: table of single-packet vectors plus
// hand-written sequences for back-pressure, FIFO admission and reset.
module tb_pac_dispatch;
  import pac_pkg::*;

  localparam int unsigned DD = 32;
  localparam int unsigned AD = 8;
  localparam int unsigned MW = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [133:0] in_pac_data;
  logic         in_pac_data_wr, in_pac_valid, in_pac_valid_wr;
  logic [10:0]  in_pac_action;
  logic         in_pac_action_wr;
  logic [133:0] out_p0_data, out_p1_data, out_p2_data;
  logic         out_p0_data_wr, out_p1_data_wr, out_p2_data_wr;
  logic         out_p0_valid_wr, out_p1_valid_wr, out_p2_valid_wr;
  logic         out_p0_valid, out_p1_valid, out_p2_valid;
  logic         in_p0_alf, in_p1_alf, in_p2_alf;
  logic [31:0]  out_drop_cnt;
`ifdef PAC_PORT_CNT_EN
  logic [31:0]  out_p0_pkt_cnt, out_p1_pkt_cnt, out_p2_pkt_cnt;
`endif

  pac_dispatch #(.DATA_DEPTH(DD), .ACT_DEPTH(AD), .MAX_PKT_WORDS(MW)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_pac_data      (in_pac_data),
    .in_pac_data_wr   (in_pac_data_wr),
    .in_pac_valid     (in_pac_valid),
    .in_pac_valid_wr  (in_pac_valid_wr),
    .in_pac_action    (in_pac_action),
    .in_pac_action_wr (in_pac_action_wr),
    .out_p0_data      (out_p0_data),
    .out_p0_data_wr   (out_p0_data_wr),
    .out_p0_valid_wr  (out_p0_valid_wr),
    .out_p0_valid     (out_p0_valid),
    .out_p1_data      (out_p1_data),
    .out_p1_data_wr   (out_p1_data_wr),
    .out_p1_valid_wr  (out_p1_valid_wr),
    .out_p1_valid     (out_p1_valid),
    .out_p2_data      (out_p2_data),
    .out_p2_data_wr   (out_p2_data_wr),
    .out_p2_valid_wr  (out_p2_valid_wr),
    .out_p2_valid     (out_p2_valid),
    .in_p0_alf        (in_p0_alf),
    .in_p1_alf        (in_p1_alf),
    .in_p2_alf        (in_p2_alf),
    .out_drop_cnt     (out_drop_cnt)
`ifdef PAC_PORT_CNT_EN
    ,
    .out_p0_pkt_cnt   (out_p0_pkt_cnt),
    .out_p1_pkt_cnt   (out_p1_pkt_cnt),
    .out_p2_pkt_cnt   (out_p2_pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [2:0]   o_wr, o_vwr, o_val;
  logic [133:0] o_data [3];
  assign o_wr  = {out_p2_data_wr, out_p1_data_wr, out_p0_data_wr};
  assign o_vwr = {out_p2_valid_wr, out_p1_valid_wr, out_p0_valid_wr};
  assign o_val = {out_p2_valid, out_p1_valid, out_p0_valid};
  always_comb begin
    o_data[0] = out_p0_data;
    o_data[1] = out_p1_data;
    o_data[2] = out_p2_data;
  end

  logic [133:0] gotq [3][$];
  logic [133:0] expq [3][$];
  int   gotvc [3];
  int   expvc [3];
  logic gotval [3];
  logic expval [3];
  int   misalign = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   drop_exp = 0;

  // Output monitor: collect words, count valid_wr and check it rides the last word
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < 3; p++) begin
        if (o_wr[p]) gotq[p].push_back(o_data[p]);
        if (o_vwr[p]) begin
          gotvc[p]++;
          gotval[p] = o_val[p];
          if (!o_wr[p] || o_data[p][133:132] != TAG_LAST) misalign++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [133:0] mkword(input int id, input int i, input int n);
    logic [133:0] w;
    logic [31:0]  k;
    k = 32'(id * 256 + i);
    w = '0;
    w[133:132] = (i == 0) ? TAG_FIRST : ((i == n - 1) ? TAG_LAST : TAG_MID);
    w[31:0]    = k;
    w[131:100] = ~k;
    w[99:68]   = k * 32'h9E3779B1;
    return w;
  endfunction

  task automatic clear_bench();
    for (int p = 0; p < 3; p++) begin
      gotq[p].delete();
      expq[p].delete();
      gotvc[p]  = 0;
      expvc[p]  = 0;
      gotval[p] = 1'b0;
      expval[p] = 1'b0;
    end
    misalign = 0;
  endtask

  task automatic send_packet(input int id, input int n, input logic [10:0] act,
                             input logic vld, input int dly, input logic [2:0] emask);
    for (int p = 0; p < 3; p++) begin
      if (emask[p]) begin
        for (int i = 0; i < n; i++) expq[p].push_back(mkword(id, i, n));
        expvc[p]++;
        expval[p] = vld;
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      in_pac_data      = mkword(id, i, n);
      in_pac_data_wr   = 1'b1;
      in_pac_action    = act;
      in_pac_action_wr = (i == dly);
      in_pac_valid     = vld;
      in_pac_valid_wr  = (i == n - 1);
      @(posedge clk); #1;
    end
    in_pac_data      = '0;
    in_pac_data_wr   = 1'b0;
    in_pac_action    = '0;
    in_pac_action_wr = 1'b0;
    in_pac_valid     = 1'b0;
    in_pac_valid_wr  = 1'b0;
  endtask

  task automatic check_ports(input string tag);
    for (int p = 0; p < 3; p++) begin
      int mism;
      int nmin;
      mism = 0;
      nmin = (gotq[p].size() < expq[p].size()) ? gotq[p].size() : expq[p].size();
      for (int i = 0; i < nmin; i++) if (gotq[p][i] !== expq[p][i]) mism++;
      check($sformatf("%s_p%0d_words", tag, p), gotq[p].size(), expq[p].size());
      check($sformatf("%s_p%0d_data", tag, p), mism, 0);
      check($sformatf("%s_p%0d_vwr", tag, p), gotvc[p], expvc[p]);
      if (expvc[p] > 0)
        check($sformatf("%s_p%0d_valid", tag, p), 32'(gotval[p]), 32'(expval[p]));
    end
    check($sformatf("%s_vwr_align", tag), misalign, 0);
    clear_bench();
  endtask

  typedef struct {
    logic [10:0] act;
    logic        vld;
    int          n;
    int          dly;
    logic [2:0]  mask;
    int          drop;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int  c;
    bit  found;

    vecs[0] = '{11'h001, 1'b1, 4, 1, 3'b010, 0};  // unicast ring 1
    vecs[1] = '{11'h401, 1'b0, 5, 2, 3'b110, 0};  // broadcast port1 + direct
    vecs[2] = '{11'h005, 1'b1, 4, 1, 3'b000, 1};  // illegal port -> discard
    vecs[3] = '{11'h000, 1'b1, 6, 3, 3'b001, 0};  // unicast ring 0
    vecs[4] = '{11'h002, 1'b1, 2, 1, 3'b100, 0};  // action with last word
    vecs[5] = '{11'h400, 1'b1, 3, 2, 3'b101, 0};  // broadcast port0 + direct
    vecs[6] = '{11'h201, 1'b1, 4, 1, 3'b000, 1};  // illegal mode -> discard
    vecs[7] = '{11'h1C2, 1'b0, 3, 1, 3'b100, 0};  // pkttype ignored, port 2

    in_pac_data = '0; in_pac_data_wr = 0; in_pac_valid = 0; in_pac_valid_wr = 0;
    in_pac_action = '0; in_pac_action_wr = 0;
    in_p0_alf = 0; in_p1_alf = 0; in_p2_alf = 0;
    clear_bench();

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes", 32'({o_wr, o_vwr, o_val}), 0);
    check("rst_data", 32'(|{out_p0_data, out_p1_data, out_p2_data}), 0);
    check("rst_drop", out_drop_cnt, 0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      send_packet(100 + v, vecs[v].n, vecs[v].act, vecs[v].vld, vecs[v].dly, vecs[v].mask);
      repeat (30) @(posedge clk);
      check_ports($sformatf("vec%0d", v));
      drop_exp += vecs[v].drop;
      check($sformatf("vec%0d_drop", v), out_drop_cnt, 32'(drop_exp));
    end

    // Direct port held almost-full, then released
    @(posedge clk); #1;
    in_p2_alf = 1'b1;
    send_packet(200, 4, 11'h002, 1'b1, 2, 3'b100);
    repeat (20) @(negedge clk);
    check("alf_hold_p2", gotq[2].size(), 0);
    @(posedge clk); #1;
    in_p2_alf = 1'b0;
    c = 0; found = 0;
    for (int k = 1; k <= 10 && !found; k++) begin
      @(negedge clk);
      if (out_p2_data_wr) begin found = 1; c = k; end
    end
    check("alf_release_lat", c, 3);
    repeat (20) @(posedge clk);
    check_ports("alf");

    // Fill data FIFO to 7 free words behind a held port 0, then overflow
    @(posedge clk); #1;
    in_p0_alf = 1'b1;
    send_packet(300, 7, 11'h000, 1'b1, 1, 3'b001);
    send_packet(301, 7, 11'h000, 1'b0, 2, 3'b001);
    send_packet(302, 7, 11'h000, 1'b1, 3, 3'b001);
    send_packet(303, 4, 11'h000, 1'b1, 1, 3'b001);
    send_packet(304, 4, 11'h000, 1'b1, 1, 3'b000);
    drop_exp++;
    repeat (5) @(posedge clk);
    check("fill_drop", out_drop_cnt, 32'(drop_exp));
    check("fill_hold_p0", gotq[0].size(), 0);
    @(posedge clk); #1;
    in_p0_alf = 1'b0;
    repeat (80) @(posedge clk);
    check_ports("fill_drain");
    send_packet(305, 5, 11'h000, 1'b0, 3, 3'b001);
    repeat (30) @(posedge clk);
    check_ports("after_fill");
    check("after_fill_drop", out_drop_cnt, 32'(drop_exp));

    // Reset in the middle of a SEND
    send_packet(400, 8, 11'h001, 1'b1, 1, 3'b010);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (out_p1_data_wr) found = 1;
    end
    check("rst_mid_send_started", 32'(found), 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_strobes", 32'({o_wr, o_vwr, o_val}), 0);
    check("rst_mid_drop", out_drop_cnt, 0);
    @(posedge clk); #1;
    check("rst_mid_data", 32'(|{out_p0_data, out_p1_data, out_p2_data}), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_bench();
    drop_exp = 0;
    send_packet(401, 6, 11'h001, 1'b1, 2, 3'b010);
    repeat (30) @(posedge clk);
    check_ports("post_rst");
    check("post_rst_drop", out_drop_cnt, 32'(drop_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pac_dispatch.md
Name: pac_dispatch

Overview:
- Packet action consumer, directly downstream of the forwarding stage.
- Takes the 134-bit packet word stream, its end-of-packet valid pulse and the 11-bit forwarding action.
- Buffers packet and action, then replicates the packet to ring port 0, ring port 1 and/or the local direct port 2 as the action dictates.
- Drops packets on overflow or an illegal action; upstream has no backpressure.

Parameters:
- DATA_DEPTH, 512, data FIFO depth in 134-bit words (power of 2).
- ACT_DEPTH, 16, action FIFO depth (power of 2).
- MAX_PKT_WORDS, 128, worst-case packet length in words; used for the admission check.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- in_pac_data  in  134  packet word; [133:132]=01 first, 10 last, 11 middle.
- in_pac_data_wr  in  1  word strobe.
- in_pac_valid  in  1  packet-good flag, sampled with in_pac_valid_wr.
- in_pac_valid_wr  in  1  one-cycle pulse coincident with the last word.
- in_pac_action  in  11  [10:9] mode (00 unicast, 10 broadcast), [8:6] pkttype, [5:0] port.
- in_pac_action_wr  in  1  one pulse per packet, arriving 1–3 cycles after the first word.
- out_p0_data/out_p1_data/out_p2_data  out  134  per-port word.
- out_p0_data_wr/out_p1_data_wr/out_p2_data_wr  out  1  per-port word strobe.
- out_p0_valid_wr/out_p1_valid_wr/out_p2_valid_wr  out  1  pulse with the last word.
- out_p0_valid/out_p1_valid/out_p2_valid  out  1  copy of the stored in_pac_valid.
- in_p0_alf/in_p1_alf/in_p2_alf  in  1  downstream almost-full; ≥ MAX_PKT_WORDS of room remains when deasserted.
- out_drop_cnt  out  32  packets dropped, saturating.

Behaviour:
- Reset: all outputs 0, both FIFOs empty, FSM IDLE, drop counter 0. Reset mid-packet discards all buffered state.
- Write side, admission:
  - On a first word, admit if data FIFO free ≥ MAX_PKT_WORDS and action FIFO not full; otherwise set drop_pkt.
  - While drop_pkt is set, ignore words and the packet's action; clear it after the last word; increment out_drop_cnt once.
- Write side, storage:
  - Admitted words are written to the data FIFO.
  - At in_pac_valid_wr, bit 133 of the stored last word is unchanged; the valid bit is stored alongside the action.
  - Because the action can arrive before the last word, the action FIFO entry carries {valid, action} and is committed at the last word.
- Destination mask:
  - Unicast, port 0/1/2: only that port.
  - Broadcast: port{action[0]} plus port 2.
  - Any other mode or port value: mask 0, so the packet is discarded.
- Read FSM:
  - IDLE: when the action FIFO is non-empty, pop it and compute the mask → ARB.
  - ARB: mask==0 → DISC. All masked ports have alf low → SEND. Otherwise stay.
  - SEND: one word per cycle to every masked port. On the last word, assert valid_wr/valid → IDLE.
  - DISC: pop words without output until the last word; increment out_drop_cnt → IDLE.
- Latency: first output word appears no earlier than 3 cycles after the action commit.
- Simultaneous events: write-side and read-side increments of out_drop_cnt in the same cycle add 2.
- Bypass: a FIFO that is empty and written in the same cycle is not bypassed.

Optional Feature:
- Macro PAC_PORT_CNT_EN.
- Defined: adds out_p0_pkt_cnt, out_p1_pkt_cnt, out_p2_pkt_cnt (32 bits each, wrap-around). Each counter increments on that port's valid_wr.
- Undefined: these ports and the counters are absent.

Decomposition:
- Package pac_pkg: word width 134, tag encodings (FIRST=01, MID=11, LAST=10), action field offsets, mode codes, port index constants.
- Sub-module pac_sfifo: synchronous FIFO parameterised by width and depth, providing empty, full and used-word count. Instantiated twice.

Test Plan:
- Unicast port 1, 4-word packet, action 11'h001, valid=1 → 4 words on p1 only; valid_wr with word 4; p0/p2 silent.
- Broadcast 11'h401 → identical words on p1 and p2; p0 silent.
- Action port 6'h5 → no output; out_drop_cnt=1.
- Hold in_p2_alf=1 with a port-2 packet, release after 20 cycles → no p2 output until 3 cycles after release; packet intact.
- Fill the data FIFO to within MAX_PKT_WORDS-1 free, send a packet → dropped, drop_cnt=1; next packet after drain → forwarded.
- Assert rst mid-SEND → outputs 0 next cycle; subsequent packet forwarded correctly.
